fetch_queue: RTL and testbench

Parametrised prefetching instruction-fetch stage that replaces the single-entry IF stage of the five-level pipeline. It issues sequential reads to the synchronous inst_rom (one-cycle read latency), buffers returned {pc, inst} pairs in a DEPTH-entry FIFO, and hands them to ID with a valid/allow handshake. It redirects on exceptions (full flush) and on taken jumps/branches, preserving the MIPS delay-slot instruction.

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch stage: sequential reads of a synchronous ROM,
// a DEPTH-entry {pc, inst} FIFO toward ID, and exception / delay-slot-aware redirect.
module fetch_queue #(
  parameter logic [31:0] START_ADDR = 32'hBFC00000,
  parameter int          DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         inst_req,
  output logic [31:0]                  inst_addr,
  input  logic [31:0]                  inst,
  input  logic [32:0]                  jbr_bus,
  input  logic [32:0]                  exc_bus,
  input  logic                         ID_allow_in,
  output logic                         IF_valid,
  output logic [63:0]                  IF_ID_bus,
  output logic [31:0]                  IF_pc,
  output logic [31:0]                  IF_inst,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic          exc_valid, jbr_taken, pop, wr_en, room;
  logic [31:0]   exc_pc, jbr_target, pc_inc;
  logic [CW:0]   occupancy;

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic          pend_valid_q, pend_valid_d;
  logic [31:0]   pend_target_q, pend_target_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];

  assign exc_valid  = exc_bus[32];
  assign exc_pc     = exc_bus[31:0];
  assign jbr_taken  = jbr_bus[32];
  assign jbr_target = jbr_bus[31:0];

  // Word increment only; the low two bits ride along unchanged.
  assign pc_inc    = {pc_q[31:2] + 30'd1, pc_q[1:0]};
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign room      = occupancy < (CW+1)'(DEPTH);

  assign inst_req   = !reset && !exc_valid && !jbr_taken && room;
  assign inst_addr  = pc_q;
  assign IF_valid   = (count_q != '0);
  assign pop        = IF_valid && ID_allow_in;
  assign IF_pc      = mem_pc[rd_q];
  assign IF_inst    = mem_inst[rd_q];
  assign IF_ID_bus  = {IF_pc, IF_inst};
  assign fifo_count = count_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    rd_d          = rd_q + PW'(pop);
    wr_d          = wr_q;
    count_d       = count_q;
    wr_en         = 1'b0;
    if (exc_valid) begin
      rd_d         = '0;
      wr_d         = '0;
      count_d      = '0;
      pend_valid_d = 1'b0;
      pc_d         = exc_pc;
    end else if (jbr_taken) begin
      pend_valid_d = 1'b0;
      pc_d         = jbr_target;
      if (pop) begin
        rd_d    = '0;
        wr_d    = '0;
        count_d = '0;
      end else if (count_q != '0) begin
        // Head is the delay slot; everything younger is wrong-path.
        wr_d    = rd_q + PW'(1);
        count_d = CW'(1);
      end else if (inflight_q) begin
        wr_en   = 1'b1;
        wr_d    = wr_q + PW'(1);
        count_d = CW'(1);
      end else begin
        // Delay slot not requested yet: fetch it first, then go to the target.
        pend_valid_d  = 1'b1;
        pend_target_d = jbr_target;
        pc_d          = pc_q;
      end
    end else begin
      wr_en = inflight_q;
      if (wr_en) wr_d = wr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
      if (inst_req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pend_valid_q ? pend_target_q : pc_inc;
        pend_valid_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= START_ADDR;
      inflight_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      pend_valid_q <= pend_valid_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
    end
  end

  // Data-only state: qualified by the control flops above, so no reset needed.
  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    pend_target_q <= pend_target_d;
    if (wr_en) begin
      mem_pc[wr_q]   <= inflight_pc_q;
      mem_inst[wr_q] <= inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference of the fetch rules;
// the bench also plays the one-cycle-latency instruction ROM.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] START = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        ID_allow_in;
  logic        IF_valid;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc, IF_inst;
  logic [2:0]  fifo_count;

  fetch_queue #(.START_ADDR(START), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst(inst), .jbr_bus(jbr_bus), .exc_bus(exc_bus), .ID_allow_in(ID_allow_in),
    .IF_valid(IF_valid), .IF_ID_bus(IF_ID_bus), .IF_pc(IF_pc), .IF_inst(IF_inst),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [63:0] mq[$];
  logic [31:0] m_pc, m_infl_pc, m_pend_tgt;
  bit          m_infl, m_pend;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = START;
    m_infl = 1'b0;
    m_pend = 1'b0;
  endtask

  // One clock cycle: drive, check, advance the reference, act as ROM.
  task automatic step(input bit allow, input bit jt, input logic [31:0] jtg,
                      input bit ev, input logic [31:0] epc);
    bit          mreq, mpop, rom_req;
    logic [31:0] rom_addr;
    logic [63:0] ent, head;
    @(negedge clk);
    ID_allow_in = allow;
    jbr_bus     = {jt, jtg};
    exc_bus     = {ev, epc};
    #1;
    mreq = !ev && !jt && (mq.size() + int'(m_infl) < DEPTH);
    chk("inst_req",   64'(inst_req),   64'(mreq));
    chk("inst_addr",  64'(inst_addr),  64'(m_pc));
    chk("IF_valid",   64'(IF_valid),   64'(mq.size() != 0));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    if (mq.size() != 0) begin
      chk("IF_ID_bus", IF_ID_bus, mq[0]);
      chk("IF_inst",   64'(IF_inst), 64'(mq[0][31:0]));
    end
    rom_req  = inst_req;
    rom_addr = inst_addr;
    mpop = allow && (mq.size() != 0);
    ent  = {m_infl_pc, rom(m_infl_pc)};
    if (ev) begin
      mq.delete();
      m_pc   = epc;
      m_pend = 1'b0;
    end else if (jt) begin
      if (mpop) begin
        mq.delete();
        m_pc = jtg;  m_pend = 1'b0;
      end else if (mq.size() != 0) begin
        head = mq[0];
        mq.delete();
        mq.push_back(head);
        m_pc = jtg;  m_pend = 1'b0;
      end else if (m_infl) begin
        mq.push_back(ent);
        m_pc = jtg;  m_pend = 1'b0;
      end else begin
        m_pend     = 1'b1;
        m_pend_tgt = jtg;
      end
    end else begin
      if (mpop) void'(mq.pop_front());
      if (m_infl) mq.push_back(ent);
    end
    if (mreq) begin
      m_infl_pc = m_pc;
      m_pc      = m_pend ? m_pend_tgt : {m_pc[31:2] + 30'd1, m_pc[1:0]};
      m_pend    = 1'b0;
    end
    m_infl = mreq;
    @(posedge clk);
    #1;
    inst = rom_req ? rom(rom_addr) : $urandom;
  endtask

  task automatic run(input int n, input bit allow);
    for (int i = 0; i < n; i++) step(allow, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Stall ID until the queue reaches n entries (bounded).
  task automatic fill_to(input int n);
    for (int i = 0; i < 16 && mq.size() != n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("fill_to", 64'(fifo_count), 64'(n));
  endtask

  initial begin
    logic [31:0] r1, r2;
    reset = 1'b1;  inst = 32'h0;  ID_allow_in = 1'b0;
    jbr_bus = '0;  exc_bus = '0;
    model_reset();
    #1;
    chk("rst_IF_valid",  64'(IF_valid),   64'(0));
    chk("rst_count",     64'(fifo_count), 64'(0));
    chk("rst_inst_addr", 64'(inst_addr),  64'(START));
    chk("rst_inst_req",  64'(inst_req),   64'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run(16, 1'b1);                                    // straight-line streaming
    run(10, 1'b0);                                    // back-pressure to full
    run(8, 1'b1);

    fill_to(2);                                       // redirect keeping the head
    step(1'b0, 1'b1, 32'h80001000, 1'b0, 32'h0);
    chk("keep_head", 64'(fifo_count), 64'(1));
    run(8, 1'b1);

    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC00010);      // empty + idle, then jump: pending
    step(1'b0, 1'b1, 32'h80002000, 1'b0, 32'h0);
    run(8, 1'b1);

    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00400000);      // jump with only inflight
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h00500000, 1'b0, 32'h0);
    run(6, 1'b1);

    fill_to(4);                                       // exception beats jump, FIFO full
    step(1'b0, 1'b1, 32'h80003000, 1'b1, 32'hBFC00380);
    chk("exc_flush", 64'(fifo_count), 64'(0));
    run(6, 1'b1);

    step(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFFFFF8);      // address wrap
    run(6, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h00001002);      // low bits pass through
    run(4, 1'b1);

    fill_to(3);                                       // asynchronous reset mid-stream
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_IF_valid",  64'(IF_valid),   64'(0));
    chk("mid_rst_count",     64'(fifo_count), 64'(0));
    chk("mid_rst_inst_addr", 64'(inst_addr),  64'(START));
    chk("mid_rst_inst_req",  64'(inst_req),   64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    inst = $urandom;
    run(10, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, r1 & 32'hFFFFFFFC,
           $urandom_range(0, 29) == 0, r2 & 32'hFFFFFFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
